dragon_length_ctrl: RTL and testbench
=====================================

Name: dragon_length_ctrl

Overview:
Producer side of the dragon `lengthUpdate` interface. Collects heal events (sheep eaten) and hit events (sword/knight collision) from the collision logic, which may be held for many cycles. Converts them into at most one single-cycle HEAL/HIT pulse per frame for the dragon body segment queue. Also tracks the current body length, a post-hit invulnerability window and game-over.

Parameters:
MAX_LEN, 7, maximum body length; must match the 7 body segments; legal range 1..7.
INIT_LEN, 0, length after reset; must equal the body's reset length (all segments disabled); legal range 0..MAX_LEN.
INVULN_FRAMES, 60, frames of hit immunity after a HIT pulse; legal range 1..255.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
vsync  input  1  frame sync from the VGA timing block; a rising edge marks a frame tick
heal_event  input  1  level or pulse from collision logic; each 0->1 transition requests one grow
hit_event  input  1  level or pulse from collision logic; each 0->1 transition requests one shrink
lengthUpdate  output  2  00 = MOVE, 01 = HEAL, 10 = HIT, 11 = IDLE (never driven); non-zero for exactly one cycle per update
length  output  3  current body length, 0..MAX_LEN
invuln  output  1  high while hits are being ignored
game_over  output  1  sticky; high after a hit at length 0

Behaviour:
- One clock. The interface is fixed: clock port `clk`, reset port `reset`, reset synchronous and active-high.
- Reset values:
  - lengthUpdate = 00, length = INIT_LEN, invuln = 0, game_over = 0.
  - State = PLAY, cooldown = 0, pend_heal = pend_hit = 0.
  - prev_heal = prev_hit = 0, pre_vsync = 1 (no spurious tick at reset release).
- Reset asserted mid-operation overrides everything on that edge; any pending request is discarded.
- frame_tick (combinational) = vsync & ~pre_vsync. pre_vsync <= vsync every cycle.
- Event capture, every cycle:
  - A rising edge on heal_event sets pend_heal; a rising edge on hit_event sets pend_hit.
  - Multiple edges before service collapse into one request.
  - An event held high across reset release counts once.
- lengthUpdate defaults to 00 on every edge. A pulse is loaded only on an edge where frame_tick = 1, so it is high exactly the cycle after that edge. length updates on the same edge.
- FSM states: PLAY, INVULN, DEAD.
- PLAY, on frame_tick:
  - If pend_hit:
    - If length == 0: go to DEAD, set game_over = 1, no pulse.
    - Else: lengthUpdate = HIT, length -= 1, cooldown = INVULN_FRAMES, go to INVULN, invuln = 1.
    - Clear pend_hit. pend_heal is kept and served on a later tick (hit has priority).
  - Else if pend_heal:
    - If length < MAX_LEN: lengthUpdate = HEAL, length += 1.
    - Else: no pulse, because length is saturated.
    - Clear pend_heal in both cases.
  - No tick: hold.
- INVULN:
  - pend_hit is forced to 0 every cycle, so hits are dropped and not queued.
  - On frame_tick, pend_heal is served exactly as in PLAY.
  - On frame_tick: if cooldown == 1, go to PLAY with invuln = 0; else cooldown -= 1.
  - An expiring tick may still carry a HEAL pulse.
- DEAD: all inputs ignored, lengthUpdate = 00, length frozen, game_over = 1. Exit only via reset.
- At most one pulse per frame. HEAL and HIT are never asserted together, and 11 is never driven.
- Arithmetic: length is 3-bit unsigned with no wrap. Decrement only when non-zero; increment only when below MAX_LEN. cooldown is 8-bit unsigned.

Decomposition:
- Shared package `dragon_pkg`:
  - lengthUpdate codes MOVE = 2'b00, HEAL = 2'b01, HIT = 2'b10, IDLE = 2'b11.
  - FSM state encoding PLAY / INVULN / DEAD.
  - Constant MAX_SEGMENTS = 7.
- One sub-module `rise_detect`: registered 0->1 edge detector with a reset value parameter. Three instances: vsync (reset value 1), heal_event, hit_event (reset value 0).

Test Plan:
- Reset, then hold heal_event = 1 for 5 frames -> exactly one HEAL pulse, 1 cycle wide, the cycle after the first vsync rise; length goes 0->1.
- Seven heal edges in separate frames, then an eighth -> seven HEAL pulses, length = 7, no pulse for the eighth, pend_heal cleared.
- length = 3, hit edge and heal edge in the same frame:
  - Tick 1 -> HIT, length = 2, invuln = 1.
  - Tick 2 -> HEAL, length = 3.
- INVULN_FRAMES = 4, hit at length 3, then a hit edge every frame:
  - One HIT only; invuln falls on the 4th tick after the hit.
  - The next hit edge after that -> HIT, length = 1.
- length = 0, hit edge then tick -> game_over = 1, no pulse.
  - Later heal and hit edges give no pulses, and length stays 0.
  - reset -> game_over = 0, length = INIT_LEN.
- Reset asserted one cycle before a tick with pend_heal = 1 -> no pulse on that tick, all outputs at reset values.

Source files
------------

// File: rtl/dragon_pkg.sv
// Shared encodings for the dragon length/update interface and controller FSM.
package dragon_pkg;

   typedef enum logic [1:0] {
      LU_MOVE = 2'b00,
      LU_HEAL = 2'b01,
      LU_HIT  = 2'b10,
      LU_IDLE = 2'b11
   } lu_t;

   typedef enum logic [1:0] {
      ST_PLAY   = 2'b00,
      ST_INVULN = 2'b01,
      ST_DEAD   = 2'b10
   } state_t;

   localparam int MAX_SEGMENTS = 7;

endpackage

// File: rtl/rise_detect.sv
// Registered 0->1 edge detector; RESET_VAL sets the assumed previous level after reset.
module rise_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) prev_q <= RESET_VAL;
      else       prev_q <= d_i;
   end

   assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/dragon_length_ctrl.sv
// Turns collision heal/hit edges into at most one HEAL/HIT pulse per frame,
// tracking body length, post-hit invulnerability and sticky game-over.
module dragon_length_ctrl
   import dragon_pkg::*;
#(
   parameter int MAX_LEN       = MAX_SEGMENTS,
   parameter int INIT_LEN      = 0,
   parameter int INVULN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       heal_event,
   input  logic       hit_event,
   output logic [1:0] lengthUpdate,
   output logic [2:0] length,
   output logic       invuln,
   output logic       game_over
);

   localparam logic [2:0] MAX_L  = 3'(MAX_LEN);
   localparam logic [2:0] INIT_L = 3'(INIT_LEN);
   localparam logic [7:0] COOL_L = 8'(INVULN_FRAMES);

   logic frame_tick, heal_rise, hit_rise;

   // vsync resets its history to 1 so reset release never looks like a frame tick
   rise_detect #(.RESET_VAL(1'b1)) u_vsync_rd (
      .clk(clk), .reset(reset), .d_i(vsync), .rise_o(frame_tick));
   rise_detect #(.RESET_VAL(1'b0)) u_heal_rd (
      .clk(clk), .reset(reset), .d_i(heal_event), .rise_o(heal_rise));
   rise_detect #(.RESET_VAL(1'b0)) u_hit_rd (
      .clk(clk), .reset(reset), .d_i(hit_event), .rise_o(hit_rise));

   state_t     state_q, state_d;
   lu_t        lu_q, lu_d;
   logic [2:0] len_q, len_d;
   logic [7:0] cool_q, cool_d;
   logic       inv_q, inv_d;
   logic       go_q, go_d;
   logic       pend_heal_q, pend_heal_d;
   logic       pend_hit_q, pend_hit_d;
   logic       heal_slot;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_PLAY;
         lu_q        <= LU_MOVE;
         len_q       <= INIT_L;
         cool_q      <= 8'd0;
         inv_q       <= 1'b0;
         go_q        <= 1'b0;
         pend_heal_q <= 1'b0;
         pend_hit_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lu_q        <= lu_d;
         len_q       <= len_d;
         cool_q      <= cool_d;
         inv_q       <= inv_d;
         go_q        <= go_d;
         pend_heal_q <= pend_heal_d;
         pend_hit_q  <= pend_hit_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lu_d        = LU_MOVE;
      len_d       = len_q;
      cool_d      = cool_q;
      inv_d       = inv_q;
      go_d        = go_q;
      pend_heal_d = pend_heal_q | heal_rise;
      pend_hit_d  = pend_hit_q | hit_rise;
      heal_slot   = 1'b0;

      unique case (state_q)
         ST_PLAY: begin
            if (frame_tick) begin
               if (pend_hit_q) begin
                  // a fresh edge landing on the serving cycle becomes the next request
                  pend_hit_d = hit_rise;
                  if (len_q == 3'd0) begin
                     state_d = ST_DEAD;
                     go_d    = 1'b1;
                  end else begin
                     lu_d    = LU_HIT;
                     len_d   = len_q - 3'd1;
                     cool_d  = COOL_L;
                     inv_d   = 1'b1;
                     state_d = ST_INVULN;
                  end
               end else begin
                  heal_slot = 1'b1;
               end
            end
         end
         ST_INVULN: begin
            pend_hit_d = 1'b0;
            if (frame_tick) begin
               heal_slot = 1'b1;
               if (cool_q == 8'd1) begin
                  state_d = ST_PLAY;
                  inv_d   = 1'b0;
               end else begin
                  cool_d = cool_q - 8'd1;
               end
            end
         end
         ST_DEAD: begin
            pend_heal_d = 1'b0;
            pend_hit_d  = 1'b0;
            go_d        = 1'b1;
         end
         default: state_d = ST_PLAY;
      endcase

      if (heal_slot && pend_heal_q) begin
         pend_heal_d = heal_rise;
         if (len_q < MAX_L) begin
            lu_d  = LU_HEAL;
            len_d = len_q + 3'd1;
         end
      end
   end

   assign lengthUpdate = lu_q;
   assign length       = len_q;
   assign invuln       = inv_q;
   assign game_over    = go_q;

endmodule

// File: tb/tb_dragon_length_ctrl.sv
// Directed bench for dragon_length_ctrl (INVULN_FRAMES = 4, MAX_LEN = 7, INIT_LEN = 0).
module tb_dragon_length_ctrl;

   localparam logic [1:0] MOVE = 2'b00;
   localparam logic [1:0] HEAL = 2'b01;
   localparam logic [1:0] HIT  = 2'b10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vsync = 1'b0;
   logic       heal_event = 1'b0;
   logic       hit_event = 1'b0;
   logic [1:0] lengthUpdate;
   logic [2:0] length;
   logic       invuln;
   logic       game_over;

   int total = 0;
   int bad = 0;

   dragon_length_ctrl #(
      .MAX_LEN(7), .INIT_LEN(0), .INVULN_FRAMES(4)
   ) dut (
      .clk(clk), .reset(reset), .vsync(vsync),
      .heal_event(heal_event), .hit_event(hit_event),
      .lengthUpdate(lengthUpdate), .length(length),
      .invuln(invuln), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; vsync = 1'b0; heal_event = 1'b0; hit_event = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // one vsync rise; lu0 is the cycle right after the tick edge, lu1 the cycle after that
   task automatic frame(output logic [1:0] lu0, output logic [1:0] lu1);
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); lu0 = lengthUpdate; vsync = 1'b0;
      @(negedge clk); lu1 = lengthUpdate;
   endtask

   task automatic heal_edge();
      @(negedge clk); heal_event = 1'b1;
      @(negedge clk); heal_event = 1'b0;
   endtask

   task automatic hit_edge();
      @(negedge clk); hit_event = 1'b1;
      @(negedge clk); hit_event = 1'b0;
   endtask

   task automatic grow(input int n);
      logic [1:0] a, b;
      for (int i = 0; i < n; i++) begin
         heal_edge();
         frame(a, b);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (lengthUpdate !== MOVE) begin bad++; $display("FAIL reset_lu got=%b exp=%b", lengthUpdate, MOVE); end
      total++; if (length !== 3'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", length); end
      total++; if (invuln !== 1'b0) begin bad++; $display("FAIL reset_invuln got=%b exp=0", invuln); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_go got=%b exp=0", game_over); end
   endtask

   task automatic test_heal_hold();
      logic [1:0] a, b;
      int pulses;
      do_reset();
      heal_event = 1'b1;
      pulses = 0;
      for (int f = 0; f < 5; f++) begin
         frame(a, b);
         if (f == 0) begin
            total++; if (a !== HEAL) begin bad++; $display("FAIL hold_first got=%b exp=%b", a, HEAL); end
            total++; if (b !== MOVE) begin bad++; $display("FAIL hold_width got=%b exp=%b", b, MOVE); end
         end
         if (a != MOVE) pulses++;
         if (b != MOVE) pulses++;
      end
      heal_event = 1'b0;
      total++; if (pulses !== 1) begin bad++; $display("FAIL hold_count got=%0d exp=1", pulses); end
      total++; if (length !== 3'd1) begin bad++; $display("FAIL hold_len got=%0d exp=1", length); end
   endtask

   task automatic test_saturate();
      logic [1:0] a, b;
      logic [1:0] exp_lu;
      logic [2:0] exp_len;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         heal_edge();
         frame(a, b);
         exp_lu  = (i < 7) ? HEAL : MOVE;
         exp_len = (i < 7) ? 3'(i + 1) : 3'd7;
         total++; if (a !== exp_lu) begin bad++; $display("FAIL sat_lu[%0d] got=%b exp=%b", i, a, exp_lu); end
         total++; if (length !== exp_len) begin bad++; $display("FAIL sat_len[%0d] got=%0d exp=%0d", i, length, exp_len); end
      end
      frame(a, b);
      total++; if (a !== MOVE) begin bad++; $display("FAIL sat_cleared got=%b exp=%b", a, MOVE); end
   endtask

   task automatic test_hit_heal_same_frame();
      logic [1:0] a, b;
      do_reset();
      grow(3);
      @(negedge clk); heal_event = 1'b1; hit_event = 1'b1;
      @(negedge clk); heal_event = 1'b0; hit_event = 1'b0;
      frame(a, b);
      total++; if (a !== HIT) begin bad++; $display("FAIL prio_t1_lu got=%b exp=%b", a, HIT); end
      total++; if (length !== 3'd2) begin bad++; $display("FAIL prio_t1_len got=%0d exp=2", length); end
      total++; if (invuln !== 1'b1) begin bad++; $display("FAIL prio_t1_inv got=%b exp=1", invuln); end
      frame(a, b);
      total++; if (a !== HEAL) begin bad++; $display("FAIL prio_t2_lu got=%b exp=%b", a, HEAL); end
      total++; if (length !== 3'd3) begin bad++; $display("FAIL prio_t2_len got=%0d exp=3", length); end
   endtask

   task automatic test_invuln();
      logic [1:0] a, b;
      logic exp_inv;
      do_reset();
      grow(3);
      hit_edge();
      frame(a, b);
      total++; if (a !== HIT) begin bad++; $display("FAIL inv_hit got=%b exp=%b", a, HIT); end
      for (int t = 1; t <= 4; t++) begin
         hit_edge();
         frame(a, b);
         exp_inv = (t < 4);
         total++; if (a !== MOVE) begin bad++; $display("FAIL inv_drop[%0d] got=%b exp=%b", t, a, MOVE); end
         total++; if (invuln !== exp_inv) begin bad++; $display("FAIL inv_flag[%0d] got=%b exp=%b", t, invuln, exp_inv); end
      end
      total++; if (length !== 3'd2) begin bad++; $display("FAIL inv_len got=%0d exp=2", length); end
      hit_edge();
      frame(a, b);
      total++; if (a !== HIT) begin bad++; $display("FAIL inv_rehit got=%b exp=%b", a, HIT); end
      total++; if (length !== 3'd1) begin bad++; $display("FAIL inv_rehit_len got=%0d exp=1", length); end
   endtask

   task automatic test_dead();
      logic [1:0] a, b;
      do_reset();
      hit_edge();
      frame(a, b);
      total++; if (a !== MOVE) begin bad++; $display("FAIL dead_lu got=%b exp=%b", a, MOVE); end
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL dead_go got=%b exp=1", game_over); end
      heal_edge();
      frame(a, b);
      total++; if (a !== MOVE) begin bad++; $display("FAIL dead_heal got=%b exp=%b", a, MOVE); end
      hit_edge();
      frame(a, b);
      total++; if (a !== MOVE) begin bad++; $display("FAIL dead_hit got=%b exp=%b", a, MOVE); end
      total++; if (length !== 3'd0) begin bad++; $display("FAIL dead_len got=%0d exp=0", length); end
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL dead_sticky got=%b exp=1", game_over); end
      do_reset();
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL dead_reset_go got=%b exp=0", game_over); end
      total++; if (length !== 3'd0) begin bad++; $display("FAIL dead_reset_len got=%0d exp=0", length); end
   endtask

   task automatic test_reset_pending();
      logic [1:0] a, b;
      do_reset();
      grow(1);
      heal_edge();
      // reset lands on the edge that would otherwise be the tick serving the heal
      @(negedge clk); reset = 1'b1; vsync = 1'b1;
      @(negedge clk);
      total++; if (lengthUpdate !== MOVE) begin bad++; $display("FAIL rstp_lu got=%b exp=%b", lengthUpdate, MOVE); end
      total++; if (length !== 3'd0) begin bad++; $display("FAIL rstp_len got=%0d exp=0", length); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (lengthUpdate !== MOVE) begin bad++; $display("FAIL rstp_release got=%b exp=%b", lengthUpdate, MOVE); end
      vsync = 1'b0;
      frame(a, b);
      total++; if (a !== MOVE) begin bad++; $display("FAIL rstp_discard got=%b exp=%b", a, MOVE); end
      total++; if (length !== 3'd0 || invuln !== 1'b0 || game_over !== 1'b0) begin
         bad++; $display("FAIL rstp_outs got=len%0d/inv%b/go%b exp=len0/inv0/go0", length, invuln, game_over);
      end
   endtask

   initial begin
      test_reset();
      test_heal_hold();
      test_saturate();
      test_hit_heal_same_frame();
      test_invuln();
      test_dead();
      test_reset_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
